// File: rtl/lsu_mem_stage_pkg.sv
// Shared encodings for the LSU memory stage: access sizes, FSM states and
// the alignment / byte-enable helpers used by the top.
package lsu_mem_stage_pkg;

    localparam logic [1:0] LSU_BYTE = 2'b00;
    localparam logic [1:0] LSU_HALF = 2'b01;
    localparam logic [1:0] LSU_WORD = 2'b10;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_REQ  = 2'b01,
        LSU_WAIT = 2'b10
    } lsu_state_e;

    // Load+store together has no legal meaning and is reported as a fault.
    function automatic logic lsu_misaligned(input logic       load,
                                            input logic       store,
                                            input logic [1:0] size,
                                            input logic [1:0] off);
        logic bad;
        bad = load & store;
        case (size)
            LSU_BYTE: bad = bad;
            LSU_HALF: bad = bad | off[0];
            default:  bad = bad | (off != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_mem_stage_load_extend.sv
// Combinational load lane select and sign/zero extension of the returned word.
// Latency 0; no flow control.
module load_extend
    import lsu_mem_stage_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_off)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (i_size)
            LSU_BYTE: o_data = {{24{i_signed & w_byte[7]}}, w_byte};
            LSU_HALF: o_data = {{16{i_signed & w_half[15]}}, w_half};
            default:  o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// MIPS150 memory stage: ALU pass-through, load/store issue to data memory, misalign faults.
// Non-memory op / fault: 1 cycle. Memory ops stall execute (ex_ready=0) until the store handshakes or the load data returns.
module lsu_mem_stage
    import lsu_mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              ex_load,
    input  logic              ex_store,
    input  logic [1:0]        ex_size,
    input  logic              ex_signed,
    input  logic [ADDR_W-1:0] alu_out,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic [4:0]        ex_rd,
    output logic              mem_req,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              exc_misalign,
    output logic [ADDR_W-1:0] exc_addr
);

    lsu_state_e r_state, w_state_nxt;

    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [3:0]        r_mem_we;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_wb_valid;
    logic [4:0]        r_wb_rd;
    logic [DATA_W-1:0] r_wb_data;
    logic              r_exc;
    logic [ADDR_W-1:0] r_exc_addr;

    logic              r_is_load;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [4:0]        r_rd;
    logic [1:0]        r_off;

    logic              w_is_mem;
    logic              w_misalign;
    logic              w_accept;
    logic [3:0]        w_be;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_load_data;

    assign ex_ready   = (r_state == LSU_IDLE);
    assign w_accept   = ex_valid & ex_ready;
    assign w_is_mem   = ex_load | ex_store;
    assign w_misalign = lsu_misaligned(ex_load, ex_store, ex_size, alu_out[1:0]);

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = ex_wdata;
        case (ex_size)
            LSU_BYTE: begin
                w_be    = 4'b0001 << alu_out[1:0];
                w_wdata = {4{ex_wdata[7:0]}};
            end
            LSU_HALF: begin
                w_be    = 4'b0011 << alu_out[1:0];
                w_wdata = {2{ex_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    load_extend u_load_extend (
        .i_rdata  (mem_rdata),
        .i_off    (r_off),
        .i_size   (r_size),
        .i_signed (r_signed),
        .o_data   (w_load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= LSU_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LSU_IDLE: if (w_accept && w_is_mem && !w_misalign) w_state_nxt = LSU_REQ;
            LSU_REQ:  if (mem_ready) w_state_nxt = r_is_load ? LSU_WAIT : LSU_IDLE;
            LSU_WAIT: if (mem_rvalid) w_state_nxt = LSU_IDLE;
            default:  w_state_nxt = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_we    <= 4'b0000;
            r_mem_wdata <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_rd     <= 5'd0;
            r_wb_data   <= '0;
            r_exc       <= 1'b0;
            r_exc_addr  <= '0;
            r_is_load   <= 1'b0;
            r_size      <= LSU_WORD;
            r_signed    <= 1'b0;
            r_rd        <= 5'd0;
            r_off       <= 2'd0;
        end else begin
            r_wb_valid <= 1'b0;
            r_exc      <= 1'b0;
            case (r_state)
                LSU_IDLE: begin
                    if (w_accept) begin
                        if (!w_is_mem) begin
                            r_wb_valid <= 1'b1;
                            r_wb_data  <= alu_out;
                            r_wb_rd    <= ex_rd;
                        end else if (w_misalign) begin
                            r_exc      <= 1'b1;
                            r_exc_addr <= alu_out;
                        end else begin
                            r_mem_req   <= 1'b1;
                            r_mem_addr  <= {alu_out[ADDR_W-1:2], 2'b00};
                            r_mem_we    <= ex_store ? w_be : 4'b0000;
                            r_mem_wdata <= w_wdata;
                            r_is_load   <= ex_load;
                            r_size      <= ex_size;
                            r_signed    <= ex_signed;
                            r_rd        <= ex_rd;
                            r_off       <= alu_out[1:0];
                        end
                    end
                end
                LSU_REQ: begin
                    if (mem_ready) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 4'b0000;
                    end
                end
                LSU_WAIT: begin
                    if (mem_rvalid) begin
                        r_wb_valid <= 1'b1;
                        r_wb_rd    <= r_rd;
                        r_wb_data  <= w_load_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req      = r_mem_req;
    assign mem_addr     = r_mem_addr;
    assign mem_we       = r_mem_we;
    assign mem_wdata    = r_mem_wdata;
    assign wb_valid     = r_wb_valid;
    assign wb_rd        = r_wb_rd;
    assign wb_data      = r_wb_data;
    assign exc_misalign = r_exc;
    assign exc_addr     = r_exc_addr;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: expected writebacks/faults are queued at issue
// and a negedge monitor pops them whenever the DUT pulses wb_valid or exc_misalign.
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic        ex_load = 1'b0;
    logic        ex_store = 1'b0;
    logic [1:0]  ex_size = 2'b10;
    logic        ex_signed = 1'b0;
    logic [31:0] alu_out = '0;
    logic [31:0] ex_wdata = '0;
    logic [4:0]  ex_rd = '0;
    logic        mem_req;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exc_misalign;
    logic [31:0] exc_addr;

    typedef struct {
        logic        is_exc;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    lsu_mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_load(ex_load), .ex_store(ex_store),
        .ex_size(ex_size), .ex_signed(ex_signed), .alu_out(alu_out), .ex_wdata(ex_wdata),
        .ex_rd(ex_rd), .mem_req(mem_req), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .exc_misalign(exc_misalign), .exc_addr(exc_addr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic is_exc, input logic [4:0] rd, input logic [31:0] data);
        exp_t e;
        e.is_exc = is_exc;
        e.rd     = rd;
        e.data   = data;
        exp_q.push_back(e);
    endtask

    // Presents an op for one accepting edge; fields stay put afterwards.
    task automatic issue(input logic ld, input logic st, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
        ex_load = ld; ex_store = st; ex_size = sz; ex_signed = sg;
        alu_out = addr; ex_wdata = wd; ex_rd = rd; ex_valid = 1'b1;
        step();
        ex_valid = 1'b0;
    endtask

    task automatic do_load(input logic [1:0] sz, input logic sg, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [4:0] rd, input logic [31:0] exp);
        push(1'b0, rd, exp);
        issue(1'b1, 1'b0, sz, sg, addr, 32'h0, rd);
        chk("ld_req", {31'd0, mem_req}, 32'd1);
        chk("ld_we", {28'd0, mem_we}, 32'd0);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("ld_req_drop", {31'd0, mem_req}, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = rdata;
        step();
        mem_rvalid = 1'b0;
        chk("ld_ready_on_wb", {31'd0, ex_ready}, 32'd1);
    endtask

    always @(negedge clk) begin
        if (wb_valid === 1'b1 || exc_misalign === 1'b1) begin
            exp_t e;
            if (wb_valid === 1'b1 && exc_misalign === 1'b1) begin
                n_cmp++; n_bad++;
                $display("FAIL pulse_overlap: wb_valid and exc_misalign both 1");
            end else if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_pulse: wb=%0b exc=%0b rd=%0d data=0x%08h addr=0x%08h",
                         wb_valid, exc_misalign, wb_rd, wb_data, exc_addr);
            end else begin
                e = exp_q.pop_front();
                chk("sb_kind", {31'd0, exc_misalign}, {31'd0, e.is_exc});
                if (e.is_exc) begin
                    chk("sb_exc_addr", exc_addr, e.data);
                end else begin
                    chk("sb_wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                    chk("sb_wb_data", wb_data, e.data);
                end
            end
        end
    end

    initial begin
        step();
        step();
        chk("rst_ready", {31'd0, ex_ready}, 32'd1);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_we", {28'd0, mem_we}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_wb", {26'd0, wb_valid, wb_rd}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_exc", {31'd0, exc_misalign}, 32'd0);
        chk("rst_exc_addr", exc_addr, 32'd0);
        rst = 1'b0;
        step();

        // Non-memory pass-through
        push(1'b0, 5'd5, 32'h0000_1234);
        issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_1234, 32'h0, 5'd5);
        chk("alu_no_req", {31'd0, mem_req}, 32'd0);
        chk("alu_ready", {31'd0, ex_ready}, 32'd1);
        step();

        // SB at offset 3 with a slow memory
        issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'hAABB_CCDD, 5'd0);
        for (int i = 0; i < 4; i++) begin
            chk("sb_req", {31'd0, mem_req}, 32'd1);
            chk("sb_addr", mem_addr, 32'h0000_1000);
            chk("sb_we", {28'd0, mem_we}, 32'h8);
            chk("sb_wdata", mem_wdata, 32'hDDDD_DDDD);
            chk("sb_stall", {31'd0, ex_ready}, 32'd0);
            if (i == 3) mem_ready = 1'b1;
            step();
        end
        mem_ready = 1'b0;
        chk("sb_req_drop", {31'd0, mem_req}, 32'd0);
        chk("sb_we_clear", {28'd0, mem_we}, 32'd0);
        chk("sb_ready_back", {31'd0, ex_ready}, 32'd1);
        step();

        // SH at offset 2, accepted immediately
        issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_6002, 32'h1234_ABCD, 5'd0);
        chk("sh_addr", mem_addr, 32'h0000_6000);
        chk("sh_we", {28'd0, mem_we}, 32'hC);
        chk("sh_wdata", mem_wdata, 32'hABCD_ABCD);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("sh_ready_back", {31'd0, ex_ready}, 32'd1);

        // Half loads: signed and unsigned from the upper lane
        do_load(2'b01, 1'b1, 32'h0000_2002, 32'h8001_7FFF, 5'd9, 32'hFFFF_8001);
        do_load(2'b01, 1'b0, 32'h0000_2002, 32'h8001_7FFF, 5'd9, 32'h0000_8001);
        // LBU lane 1 with rd=0 still pulses wb_valid
        do_load(2'b00, 1'b0, 32'h0000_7001, 32'h0000_F200, 5'd0, 32'h0000_00F2);
        // Word load, size code 11 behaves as word
        do_load(2'b11, 1'b1, 32'h0000_7004, 32'h8765_4321, 5'd12, 32'h8765_4321);

        // Misaligned word and illegal load+store
        push(1'b1, 5'd0, 32'h0000_3001);
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0, 5'd3);
        chk("mis_no_req", {31'd0, mem_req}, 32'd0);
        chk("mis_ready", {31'd0, ex_ready}, 32'd1);
        push(1'b1, 5'd0, 32'h0000_3004);
        issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_3004, 32'h0, 5'd3);
        chk("ldst_no_req", {31'd0, mem_req}, 32'd0);
        step();

        // Reset with a load outstanding in WAIT
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0, 5'd7);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("wait_stall", {31'd0, ex_ready}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstw_req", {31'd0, mem_req}, 32'd0);
        chk("rstw_wb", {31'd0, wb_valid}, 32'd0);
        chk("rstw_ready", {31'd0, ex_ready}, 32'd1);
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_rvalid = 1'b0;
        push(1'b0, 5'd3, 32'h0000_0055);
        issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0055, 32'h0, 5'd3);
        step();

        // LB signed followed back-to-back by an ADD accepted on the wb cycle
        push(1'b0, 5'd4, 32'hFFFF_FF80);
        push(1'b0, 5'd6, 32'h0000_00AA);
        issue(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_5000, 32'h0, 5'd4);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_0080;
        step();
        mem_rvalid = 1'b0;
        chk("b2b_ready", {31'd0, ex_ready}, 32'd1);
        issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_00AA, 32'h0, 5'd6);
        step();
        step();
        step();

        chk("sb_drain", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
